// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - MIPS fetch stage and IF/ID pipeline register (option: FETCH_DELAY_SLOT_EN)
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          IMEM_AW  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               exc_valid,
    input  logic [31:0]        exc_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        if_pc,
    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic [5:0]         id_op,
    output logic [5:0]         id_func,
    output logic [4:0]         id_mt,
    output logic [4:0]         id_rt,
    output logic [4:0]         id_rd,
    output logic [15:0]        id_imm,
    output logic               redirect_pending
);

    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_pc_q, pending_pc_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4        = pc_q + 32'd4;
    // A fresh redirect from ID beats a stale one captured during a stall.
    assign redirect_target = redirect_valid ? redirect_pc : pending_pc_q;

    // ROM is word addressed relative to the reset vector; upper bits are dropped.
    assign imem_addr = IMEM_AW'((pc_q - RESET_PC) >> 2);

    // Next-state selection: exception > stall > redirect > pending > sequential.
    always_comb begin
        pc_d         = pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;

        if (exc_valid) begin
            pc_d       = exc_pc;
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
            id_pc_d    = 32'h0;
            id_pc4_d   = 32'h0;
            pending_d  = 1'b0;
        end else if (stall) begin
            if (redirect_valid) begin
                pending_d    = 1'b1;
                pending_pc_d = redirect_pc;
            end
        end else if (redirect_valid || pending_q) begin
            pc_d      = {redirect_target[31:2], 2'b00};
            pending_d = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            // Delay slot: the word already being fetched still executes.
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
`else
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
            id_pc_d    = 32'h0;
            id_pc4_d   = 32'h0;
`endif
        end else begin
            pc_d       = pc_plus4;
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
        end
    end

    // PC, IF/ID and pending-redirect registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'h0;
            id_pc_q      <= 32'h0;
            id_pc4_q     <= 32'h0;
            pending_q    <= 1'b0;
            pending_pc_q <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    assign if_pc            = pc_q;
    assign id_valid         = id_valid_q;
    assign id_instr         = id_instr_q;
    assign id_pc            = id_pc_q;
    assign id_pc4           = id_pc4_q;
    assign redirect_pending = pending_q;

    assign id_op   = id_instr_q[31:26];
    assign id_func = id_instr_q[5:0];
    assign id_mt   = id_instr_q[25:21];
    assign id_rt   = id_instr_q[20:16];
    assign id_rd   = id_instr_q[15:11];
    assign id_imm  = id_instr_q[15:0];

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - directed self-checking bench for if_id_fetch_stage
module tb_if_id_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] WA  = 32'h2408_0001;
    localparam logic [31:0] WB  = 32'h2409_0002;
    localparam logic [31:0] WC  = 32'h012A_5820;
    localparam logic [31:0] WL  = 32'h8D2A_7FFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [5:0]  id_op;
    logic [5:0]  id_func;
    logic [4:0]  id_mt;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [15:0] id_imm;
    logic        redirect_pending;

    logic [31:0] rom [0:2047];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr];

    if_id_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_valid(exc_valid), .exc_pc(exc_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_op(id_op), .id_func(id_func),
        .id_mt(id_mt), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .redirect_pending(redirect_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 32'hA500_0000 | i;
        rom[0]     = WA;
        rom[1]     = WB;
        rom[2]     = WC;
        rom[11'h40] = WL;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        exc_valid = 1'b0; exc_pc = 32'h0;
        step(); step();
        chk("rst_pc", if_pc, RPC);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_pending", {31'h0, redirect_pending}, 32'h0);
        chk("rst_addr", {21'h0, imem_addr}, 32'h0);

        rst = 1'b0;
        step();
        chk("seq1_pc", if_pc, 32'h0040_0004);
        chk("seq1_instr", id_instr, WA);
        chk("seq1_idpc", id_pc, 32'h0040_0000);
        chk("seq1_pc4", id_pc4, 32'h0040_0004);
        chk("seq1_valid", {31'h0, id_valid}, 32'h1);
        step();
        chk("seq2_pc", if_pc, 32'h0040_0008);
        chk("seq2_instr", id_instr, WB);
        chk("seq2_pc4", id_pc4, 32'h0040_0008);

        // Redirect with misaligned target while fetching ROM[2].
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
        step();
        redirect_valid = 1'b0;
        chk("redir_pc", if_pc, 32'h0040_0100);
        chk("redir_addr", {21'h0, imem_addr}, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
        chk("redir_valid", {31'h0, id_valid}, 32'h1);
        chk("redir_instr", id_instr, WC);
        chk("redir_idpc", id_pc, 32'h0040_0008);
        chk("redir_pc4", id_pc4, 32'h0040_000C);
`else
        chk("redir_valid", {31'h0, id_valid}, 32'h0);
        chk("redir_instr", id_instr, 32'h0);
`endif
        step();
        chk("tgt_pc", if_pc, 32'h0040_0104);
        chk("tgt_instr", id_instr, WL);
        chk("tgt_idpc", id_pc, 32'h0040_0100);
        chk("tgt_op", {26'h0, id_op}, 32'h23);
        chk("tgt_mt", {27'h0, id_mt}, 32'h09);
        chk("tgt_rt", {27'h0, id_rt}, 32'h0A);
        chk("tgt_rd", {27'h0, id_rd}, 32'h0F);
        chk("tgt_func", {26'h0, id_func}, 32'h3C);
        chk("tgt_imm", {16'h0, id_imm}, 32'h7FFC);

        // Three stall cycles, redirect arriving in the second.
        stall = 1'b1;
        step();
        chk("stall1_pc", if_pc, 32'h0040_0104);
        chk("stall1_instr", id_instr, WL);
        chk("stall1_pend", {31'h0, redirect_pending}, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0040;
        step();
        redirect_valid = 1'b0;
        chk("stall2_pc", if_pc, 32'h0040_0104);
        chk("stall2_pend", {31'h0, redirect_pending}, 32'h1);
        step();
        chk("stall3_pc", if_pc, 32'h0040_0104);
        chk("stall3_idpc", id_pc, 32'h0040_0100);
        chk("stall3_pend", {31'h0, redirect_pending}, 32'h1);
        stall = 1'b0;
        step();
        chk("pend_pc", if_pc, 32'h0040_0040);
        chk("pend_clr", {31'h0, redirect_pending}, 32'h0);
`ifdef FETCH_DELAY_SLOT_EN
        chk("pend_valid", {31'h0, id_valid}, 32'h1);
        chk("pend_instr", id_instr, 32'hA500_0041);
`else
        chk("pend_valid", {31'h0, id_valid}, 32'h0);
        chk("pend_instr", id_instr, 32'h0);
`endif

        // Capture a pending redirect, then an exception with stall+redirect.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
        step();
        chk("pre_exc_pend", {31'h0, redirect_pending}, 32'h1);
        exc_valid = 1'b1; exc_pc = 32'h0040_4180;
        step();
        exc_valid = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        chk("exc_pc", if_pc, 32'h0040_4180);
        chk("exc_valid", {31'h0, id_valid}, 32'h0);
        chk("exc_instr", id_instr, 32'h0);
        chk("exc_pend", {31'h0, redirect_pending}, 32'h0);

        step();
        chk("post_exc_pc", if_pc, 32'h0040_4184);
        chk("post_exc_instr", id_instr, 32'hA500_0060);
        chk("post_exc_valid", {31'h0, id_valid}, 32'h1);

        // Reset while a redirect is pending.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0300;
        step();
        chk("pre_rst_pend", {31'h0, redirect_pending}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        chk("mrst_pc", if_pc, RPC);
        chk("mrst_pend", {31'h0, redirect_pending}, 32'h0);
        chk("mrst_valid", {31'h0, id_valid}, 32'h0);

        // PC wrap at the top of the address space.
        exc_valid = 1'b1; exc_pc = 32'hFFFF_FFFC;
        step();
        exc_valid = 1'b0;
        chk("top_pc", if_pc, 32'hFFFF_FFFC);
        chk("top_addr", {21'h0, imem_addr}, 32'h7FF);
        step();
        chk("wrap_pc", if_pc, 32'h0000_0000);
        chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc4, 32'h0000_0000);
        chk("wrap_instr", id_instr, 32'hA500_07FF);
        chk("wrap_addr", {21'h0, imem_addr}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 54-instruction static MIPS pipeline.
- Holds the PC and reads the instruction ROM combinationally.
- Registers the fetched word and its PC into IF/ID, and drives op/func/MT fields straight into the instruction decoder.
- Handles hazard stall, branch/jump redirect from ID (including redirects arriving during stall) and exception/ERET redirect from CP0.

Parameters:
RESET_PC, 32'h0040_0000, PC value after reset; also the base of the instruction ROM.
IMEM_AW, 11, instruction ROM word-address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  1  hazard-unit hold of PC and IF/ID.
redirect_valid  in  1  branch/jump taken in ID.
redirect_pc  in  32  branch/jump target.
exc_valid  in  1  exception entry or ERET from CP0.
exc_pc  in  32  exception vector or EPC.
imem_addr  out  IMEM_AW  ROM word address = ((pc - RESET_PC) >> 2), truncated.
imem_rdata  in  32  ROM data, combinational from imem_addr.
if_pc  out  32  current fetch PC.
id_valid  out  1  IF/ID holds a real instruction.
id_instr  out  32  registered instruction word.
id_pc  out  32  PC of id_instr.
id_pc4  out  32  id_pc + 4.
id_op  out  6  id_instr[31:26].
id_func  out  6  id_instr[5:0].
id_mt  out  5  id_instr[25:21].
id_rt  out  5  id_instr[20:16].
id_rd  out  5  id_instr[15:11].
id_imm  out  16  id_instr[15:0].
redirect_pending  out  1  a redirect was captured during stall and not yet applied.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; id_valid=0; id_instr=0; id_pc=0; id_pc4=0; pending=0; pending_pc=0. Overrides all other inputs.
- Field outputs are pure slices of id_instr.
- id_instr=0 decodes as SLL $0 (a nop); every bubble must write id_instr=0.
- Per-edge priority: rst > exc_valid > stall > redirect_valid > pending > sequential.
- exc_valid: pc<=exc_pc; IF/ID becomes a bubble (id_valid=0, id_instr=0); pending cleared. Applies even when stall=1.
- stall (no exc): pc and IF/ID hold.
  - If redirect_valid=1, set pending=1 and pending_pc=redirect_pc; the latest redirect overwrites an older pending one.
- redirect_valid (no stall): pc<=redirect_pc; pending cleared. IF/ID handling is set by the optional feature.
- pending=1, no stall, no redirect: pc<=pending_pc; pending cleared; IF/ID handled as for a redirect.
- Sequential: pc<=pc+4; IF/ID<={imem_rdata, pc, pc+4}; id_valid=1.
- Redirect target low two bits are forced to 00 when loaded into pc.
- pc+4 wraps modulo 2^32. imem_addr wraps modulo 2^IMEM_AW.
- Latency: instruction at PC X appears on id_instr one edge after if_pc==X, when not stalled.
- Mid-operation reset discards pending redirects and IF/ID contents.

Optional Feature:
Macro: FETCH_DELAY_SLOT_EN
- Defined (MIPS delay-slot semantics): on a redirect or pending redirect, IF/ID loads the instruction currently being fetched, with id_valid=1. pc still jumps to the target.
- Undefined: on a redirect or pending redirect, IF/ID becomes a bubble (id_valid=0, id_instr=0).
- Exception handling is identical in both builds; exceptions always bubble.

Test Plan:
- Reset then 3 free-running cycles, ROM[0..2]=A,B,C -> if_pc 0x00400000, 0x00400004, 0x00400008; id_instr A, B, C; id_pc4 0x00400004, 0x00400008, 0x0040000C.
- redirect_valid=1, redirect_pc=0x00400103 at if_pc=0x00400008 -> next if_pc=0x00400100. IF/ID is a bubble (0, valid 0) without the macro; IF/ID holds ROM[2] with valid 1 with FETCH_DELAY_SLOT_EN.
- stall=1 for 3 cycles with redirect to 0x00400040 in stall cycle 2 -> pc and IF/ID frozen, redirect_pending=1; on the first unstalled edge if_pc=0x00400040 and redirect_pending=0.
- exc_valid=1, exc_pc=0x00404180 together with stall=1 and redirect_valid=1 -> if_pc=0x00404180, id_valid=0, id_instr=0, redirect_pending=0.
- rst asserted for one cycle while redirect_pending=1 -> if_pc=RESET_PC, redirect_pending=0, id_valid=0.
- pc=0xFFFFFFFC sequential -> if_pc wraps to 0x00000000; id_pc4=0x00000000.
